core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: isALUreg, isALUimm, isBranch, isJAL, isJALR, isLUI, isAUIPC, isLoad, isStore, isSYSTEM  in  1 each  opcode class flags from instruction decoder.
REQ-006 SHALL have ports: takeBranch  in  1  branch condition true (valid in EXECUTE).
REQ-007 SHALL have ports: imem_req out 1, imem_ready in 1, dmem_req out 1, dmem_we out 1, dmem_ready in 1  memory handshakes.
REQ-008 SHALL have ports: irWrite out 1, pcWrite out 1, pcSel out 2 (0 PC+4, 1 PC+imm, 2 rs1+imm), regWriteEn out 1, halted out 1, retired out CNT_W.

Function
REQ-009 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WB, HALT; one state per cycle unless stalled.
REQ-010 FETCH: imem_req=1; SHALL stay until imem_ready=1, then irWrite=1 for that cycle and go DECODE.
REQ-011 DECODE: one cycle, no strobes; SHALL go HALT if isSYSTEM, else EXECUTE.
REQ-012 DECODE with no flag set (illegal opcode) SHALL go HALT.
REQ-013 EXECUTE: isLoad/isStore -> MEM; all other classes -> WB.
REQ-014 MEM: dmem_req=1, dmem_we=isStore; SHALL hold both stable until dmem_ready=1, then go WB.
REQ-015 WB: regWriteEn=1 iff isALUreg|isALUimm|isLoad|isLUI|isAUIPC|isJAL|isJALR; pcWrite=1; then FETCH.
REQ-016 pcSel in WB: 2 if isJALR; 1 if isJAL or (isBranch and takeBranch); else 0.
REQ-017 takeBranch SHALL be sampled in EXECUTE into a register; value on takeBranch outside EXECUTE ignored.
REQ-018 irWrite, pcWrite, regWriteEn SHALL each be single-cycle pulses, never asserted outside their state.
REQ-019 retired SHALL increment by 1 in each WB cycle; wraps from all-ones to 0 without flag.
REQ-020 HALT: absorbing; all strobes and requests 0; halted=1; only reset exits.
REQ-021 imem_ready or dmem_ready asserted while the corresponding request is 0 SHALL be ignored.
REQ-022 Decoder flags SHALL be treated as valid from DECODE through WB (instruction register held stable).
REQ-023 Minimum latency: ALU/jump/branch instr = 4 cycles (FETCH, DECODE, EXECUTE, WB) with zero-wait imem; load/store = 5.

Reset
REQ-024 rst_n=0 SHALL immediately force state FETCH, retired=0, halted=0, all strobes/requests 0, captured takeBranch 0.
REQ-025 Reset asserted mid-MEM SHALL drop dmem_req same instant; no write pulse issued after release.
REQ-026 After rst_n deasserts, first rising edge SHALL begin FETCH with imem_req=1; PC owner loads RESET_PC.

Verification
REQ-027 ADD (isALUreg) with imem_ready tied 1 -> irWrite cycle 1, regWriteEn+pcWrite cycle 4, pcSel=0, retired=1.
REQ-028 LW, dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles, then WB regWriteEn=1, total 8 cycles.
REQ-029 SW -> dmem_we=1 in MEM, WB regWriteEn=0, pcWrite=1.
REQ-030 BEQ with takeBranch=1 in EXECUTE then 0 -> pcSel=1 in WB; with 0 in EXECUTE then 1 -> pcSel=0.
REQ-031 ECALL (isSYSTEM) -> HALT after DECODE, halted=1, no further imem_req for 20 cycles; illegal opcode same.
REQ-032 rst_n pulsed low during MEM of SW -> dmem_req falls asynchronously, retired=0, restart in FETCH.

Source files
------------

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - instruction/data memory handshake bundle for core_sequencer
interface core_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  // Sequencer side: issues requests, observes ready
  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  // Memory side: observes requests, returns ready
  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32 control sequencer (fetch/decode/execute/mem/wb/halt)
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 isALUreg,
  input  logic                 isALUimm,
  input  logic                 isBranch,
  input  logic                 isJAL,
  input  logic                 isJALR,
  input  logic                 isLUI,
  input  logic                 isAUIPC,
  input  logic                 isLoad,
  input  logic                 isStore,
  input  logic                 isSYSTEM,
  input  logic                 takeBranch,
  core_sequencer_if.master     mem,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic [1:0]           pcSel,
  output logic                 regWriteEn,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_take;
  logic [CNT_W-1:0]   r_retired;

  logic               w_imem_req;
  logic               w_ir_write;
  logic               w_dmem_req;
  logic               w_dmem_we;
  logic               w_pc_write;
  logic [1:0]         w_pc_sel;
  logic               w_reg_write;
  logic               w_halted;
  logic               w_any_class;
  logic               w_writes_rd;
  logic               w_is_mem;

  // The PC register lives in the datapath; the reset vector is carried here
  // so the whole core is configured from one place.
  logic               w_unused_reset_pc;
  assign w_unused_reset_pc = ^RESET_PC;

  assign w_any_class = isALUreg | isALUimm | isBranch | isJAL | isJALR |
                       isLUI | isAUIPC | isLoad | isStore | isSYSTEM;
  assign w_writes_rd = isALUreg | isALUimm | isLoad | isLUI | isAUIPC | isJAL | isJALR;
  assign w_is_mem    = isLoad | isStore;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    w_next      = r_state;
    w_imem_req  = 1'b0;
    w_ir_write  = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_sel    = 2'd0;
    w_reg_write = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (mem.imem_ready) begin
          w_ir_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (isSYSTEM || !w_any_class) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_next = w_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = isStore;
        if (mem.dmem_ready) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_pc_write  = 1'b1;
        w_reg_write = w_writes_rd;
        if (isJALR) begin
          w_pc_sel = 2'd2;
        end else if (isJAL || (isBranch && r_take)) begin
          w_pc_sel = 2'd1;
        end
        w_next = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Branch condition is only meaningful while executing; hold it for WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_take <= 1'b0;
    end else if (r_state == S_EXECUTE) begin
      r_take <= takeBranch;
    end
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_state == S_WB) begin
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset lands in FETCH, so fetch outputs are masked while reset is held
  assign mem.imem_req = w_imem_req & rst_n;
  assign irWrite      = w_ir_write & rst_n;
  assign mem.dmem_req = w_dmem_req;
  assign mem.dmem_we  = w_dmem_we;
  assign pcWrite      = w_pc_write;
  assign pcSel        = w_pc_sel;
  assign regWriteEn   = w_reg_write;
  assign halted       = w_halted;
  assign retired      = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

  localparam logic [9:0] F_ALUREG = 10'b1000000000;
  localparam logic [9:0] F_ALUIMM = 10'b0100000000;
  localparam logic [9:0] F_BRANCH = 10'b0010000000;
  localparam logic [9:0] F_JAL    = 10'b0001000000;
  localparam logic [9:0] F_JALR   = 10'b0000100000;
  localparam logic [9:0] F_LUI    = 10'b0000010000;
  localparam logic [9:0] F_AUIPC  = 10'b0000001000;
  localparam logic [9:0] F_LOAD   = 10'b0000000100;
  localparam logic [9:0] F_STORE  = 10'b0000000010;
  localparam logic [9:0] F_SYSTEM = 10'b0000000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       isALUreg = 1'b0, isALUimm = 1'b0, isBranch = 1'b0, isJAL = 1'b0, isJALR = 1'b0;
  logic       isLUI = 1'b0, isAUIPC = 1'b0, isLoad = 1'b0, isStore = 1'b0, isSYSTEM = 1'b0;
  logic       takeBranch = 1'b0;
  logic       irWrite, pcWrite, regWriteEn, halted;
  logic [1:0] pcSel;
  logic [2:0] retired;

  int n_pass  = 0;
  int n_total = 0;

  core_sequencer_if mem_if ();

  core_sequencer #(
    .RESET_PC (32'h0000_1000),
    .CNT_W    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .isALUreg   (isALUreg),
    .isALUimm   (isALUimm),
    .isBranch   (isBranch),
    .isJAL      (isJAL),
    .isJALR     (isJALR),
    .isLUI      (isLUI),
    .isAUIPC    (isAUIPC),
    .isLoad     (isLoad),
    .isStore    (isStore),
    .isSYSTEM   (isSYSTEM),
    .takeBranch (takeBranch),
    .mem        (mem_if),
    .irWrite    (irWrite),
    .pcWrite    (pcWrite),
    .pcSel      (pcSel),
    .regWriteEn (regWriteEn),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [9:0] f);
    {isALUreg, isALUimm, isBranch, isJAL, isJALR, isLUI, isAUIPC, isLoad, isStore, isSYSTEM} = f;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    set_flags(10'b0);
    mem_if.imem_ready = 1'b0;
    mem_if.dmem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_total++; if (mem_if.imem_req !== 1'b0) $display("FAIL rst_imem_req got %0b want 0", mem_if.imem_req); else n_pass++;
    n_total++; if (mem_if.dmem_req !== 1'b0) $display("FAIL rst_dmem_req got %0b want 0", mem_if.dmem_req); else n_pass++;
    n_total++; if ({irWrite, pcWrite, regWriteEn} !== 3'b000) $display("FAIL rst_strobes got %b want 000", {irWrite, pcWrite, regWriteEn}); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL rst_halted got %0b want 0", halted); else n_pass++;
    n_total++; if (retired !== 3'd0) $display("FAIL rst_retired got %0d want 0", retired); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (mem_if.imem_req !== 1'b1) $display("FAIL rel_imem_req got %0b want 1", mem_if.imem_req); else n_pass++;
    tick();
    tick();
    n_total++; if ({mem_if.imem_req, irWrite} !== 2'b10) $display("FAIL fetch_stall got %b want 10", {mem_if.imem_req, irWrite}); else n_pass++;
  endtask

  task automatic test_add;
    set_flags(F_ALUREG);
    mem_if.imem_ready = 1'b1;
    #1;
    n_total++; if (irWrite !== 1'b1) $display("FAIL add_irwrite got %0b want 1", irWrite); else n_pass++;
    tick();
    n_total++; if ({irWrite, mem_if.imem_req, pcWrite} !== 3'b000) $display("FAIL add_decode got %b want 000", {irWrite, mem_if.imem_req, pcWrite}); else n_pass++;
    tick();
    tick();
    n_total++; if ({regWriteEn, pcWrite, pcSel} !== 4'b1100) $display("FAIL add_wb got %b want 1100", {regWriteEn, pcWrite, pcSel}); else n_pass++;
    tick();
    n_total++; if (retired !== 3'd1) $display("FAIL add_retired got %0d want 1", retired); else n_pass++;
    n_total++; if ({pcWrite, regWriteEn, irWrite} !== 3'b001) $display("FAIL add_next got %b want 001", {pcWrite, regWriteEn, irWrite}); else n_pass++;
  endtask

  task automatic test_load_wait;
    int cycles;
    int held;
    set_flags(F_LOAD);
    mem_if.imem_ready = 1'b1;
    mem_if.dmem_ready = 1'b0;
    cycles = 1;
    held = 0;
    tick(); cycles++;
    mem_if.dmem_ready = 1'b1;
    tick(); cycles++;
    mem_if.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); cycles++;
      if (i == 3) mem_if.dmem_ready = 1'b1;
      #1;
      if (mem_if.dmem_req === 1'b1 && mem_if.dmem_we === 1'b0) held++;
    end
    n_total++; if (held !== 4) $display("FAIL lw_mem_held got %0d want 4", held); else n_pass++;
    tick(); cycles++;
    mem_if.dmem_ready = 1'b0;
    n_total++; if ({regWriteEn, pcWrite, mem_if.dmem_req} !== 3'b110) $display("FAIL lw_wb got %b want 110", {regWriteEn, pcWrite, mem_if.dmem_req}); else n_pass++;
    n_total++; if (cycles !== 8) $display("FAIL lw_latency got %0d want 8", cycles); else n_pass++;
    tick();
    n_total++; if (retired !== 3'd2) $display("FAIL lw_retired got %0d want 2", retired); else n_pass++;
  endtask

  task automatic test_store;
    set_flags(F_STORE);
    mem_if.imem_ready = 1'b1;
    mem_if.dmem_ready = 1'b1;
    tick();
    tick();
    tick();
    n_total++; if ({mem_if.dmem_req, mem_if.dmem_we} !== 2'b11) $display("FAIL sw_mem got %b want 11", {mem_if.dmem_req, mem_if.dmem_we}); else n_pass++;
    tick();
    mem_if.dmem_ready = 1'b0;
    n_total++; if ({regWriteEn, pcWrite, mem_if.dmem_we} !== 3'b010) $display("FAIL sw_wb got %b want 010", {regWriteEn, pcWrite, mem_if.dmem_we}); else n_pass++;
    tick();
  endtask

  task automatic test_branch(input logic t_exec, input logic [1:0] want_sel, input string name);
    set_flags(F_BRANCH);
    mem_if.imem_ready = 1'b1;
    tick();
    takeBranch = ~t_exec;
    tick();
    takeBranch = t_exec;
    tick();
    takeBranch = ~t_exec;
    #1;
    n_total++; if ({pcSel, pcWrite, regWriteEn} !== {want_sel, 2'b10}) $display("FAIL %s got %b want %b", name, {pcSel, pcWrite, regWriteEn}, {want_sel, 2'b10}); else n_pass++;
    tick();
    takeBranch = 1'b0;
  endtask

  task automatic test_jumps;
    set_flags(F_JAL);
    tick(); tick(); tick();
    n_total++; if ({pcSel, regWriteEn} !== 3'b011) $display("FAIL jal_wb got %b want 011", {pcSel, regWriteEn}); else n_pass++;
    tick();
    set_flags(F_JALR);
    tick(); tick(); tick();
    n_total++; if ({pcSel, regWriteEn} !== 3'b101) $display("FAIL jalr_wb got %b want 101", {pcSel, regWriteEn}); else n_pass++;
    tick();
    n_total++; if (retired !== 3'd7) $display("FAIL retired_seven got %0d want 7", retired); else n_pass++;
    set_flags(F_LUI);
    tick(); tick(); tick(); tick();
    n_total++; if (retired !== 3'd0) $display("FAIL retired_wrap got %0d want 0", retired); else n_pass++;
  endtask

  task automatic test_reset_mid_mem;
    set_flags(F_AUIPC);
    tick(); tick(); tick(); tick();
    set_flags(F_STORE);
    mem_if.dmem_ready = 1'b0;
    tick(); tick(); tick();
    n_total++; if ({mem_if.dmem_req, mem_if.dmem_we, retired} !== {2'b11, 3'd1}) $display("FAIL mid_mem_pre got %b want 11001", {mem_if.dmem_req, mem_if.dmem_we, retired}); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({mem_if.dmem_req, mem_if.dmem_we} !== 2'b00) $display("FAIL mid_mem_async got %b want 00", {mem_if.dmem_req, mem_if.dmem_we}); else n_pass++;
    n_total++; if (retired !== 3'd0) $display("FAIL mid_mem_retired got %0d want 0", retired); else n_pass++;
    tick();
    mem_if.dmem_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_total++; if ({mem_if.imem_req, irWrite, mem_if.dmem_req} !== 3'b110) $display("FAIL mid_mem_restart got %b want 110", {mem_if.imem_req, irWrite, mem_if.dmem_req}); else n_pass++;
    tick();
    n_total++; if ({mem_if.dmem_req, pcWrite} !== 2'b00) $display("FAIL mid_mem_nowrite got %b want 00", {mem_if.dmem_req, pcWrite}); else n_pass++;
    mem_if.dmem_ready = 1'b0;
  endtask

  task automatic test_halt(input logic [9:0] f, input string name);
    int bad;
    do_reset();
    set_flags(f);
    mem_if.imem_ready = 1'b1;
    tick();
    n_total++; if (halted !== 1'b0) $display("FAIL %s_decode_halted got %0b want 0", name, halted); else n_pass++;
    tick();
    n_total++; if ({halted, mem_if.imem_req} !== 2'b10) $display("FAIL %s_halt got %b want 10", name, {halted, mem_if.imem_req}); else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      mem_if.dmem_ready = i[0];
      tick();
      if ({mem_if.imem_req, mem_if.dmem_req, irWrite, pcWrite, regWriteEn} !== 5'b0 || halted !== 1'b1) bad++;
    end
    mem_if.dmem_ready = 1'b0;
    n_total++; if (bad !== 0) $display("FAIL %s_absorb got %0d bad cycles want 0", name, bad); else n_pass++;
    n_total++; if (retired !== 3'd0) $display("FAIL %s_retired got %0d want 0", name, retired); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_branch(1'b1, 2'd1, "beq_taken");
    test_branch(1'b0, 2'd0, "beq_not_taken");
    test_jumps();
    test_reset_mid_mem();
    test_halt(F_SYSTEM, "ecall");
    test_halt(10'b0, "illegal");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
